// File: rtl/button_step_ctrl.sv
// button_step_ctrl: turns two raw, bouncy push-buttons into a 1-cycle step
// pulse and a held direction level for an up/down counter.
//   clk       in  system clock, rising edge
//   rst       in  asynchronous active-high reset
//   btn_up    in  raw up button (async, 1 = pressed)
//   btn_down  in  raw down button (async, 1 = pressed)
//   enable    out registered 1-cycle step pulse
//   direction out registered direction level (1 = up, 0 = down)
//   lockout   out registered, high while the press FSM is in LOCK
module button_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic direction,
  output logic lockout
);

  localparam int unsigned NBTN = 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PER_LIM  = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  // Index 0 = up, index 1 = down
  logic [NBTN-1:0] sync1, sync2, db;
  logic [CNT_W-1:0] db_cnt [NBTN];
  logic [NBTN-1:0] btn_raw;

  assign btn_raw = {btn_down, btn_up};

  // Two-flop synchronisers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Stable-count debouncers: a level is accepted after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement with the current debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX || (db_cnt[i] + CNT_W'(1)) >= DB_LIM) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  logic db_up, db_dn;
  assign db_up = db[0];
  assign db_dn = db[1];

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             enable_nxt, direction_nxt, lockout_nxt;
  logic             active_c, other_c;

  // The held direction identifies which button owns the current press
  assign active_c = direction ? db_up : db_dn;
  assign other_c  = direction ? db_dn : db_up;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rpt_cnt   <= '0;
      enable    <= 1'b0;
      direction <= 1'b1;
      lockout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rpt_cnt   <= rpt_cnt_nxt;
      enable    <= enable_nxt;
      direction <= direction_nxt;
      lockout   <= lockout_nxt;
    end
  end

  // Press FSM. rpt_cnt holds cycles since the last pulse (1 on the pulse
  // edge itself) and saturates. A pulse is never issued while enable is
  // already high, so pulses can never be back-to-back.
  always_comb begin
    state_nxt     = state;
    enable_nxt    = 1'b0;
    direction_nxt = direction;
    rpt_cnt_nxt   = (rpt_cnt == CNT_MAX) ? rpt_cnt : rpt_cnt + CNT_W'(1);

    unique case (state)
      IDLE: begin
        rpt_cnt_nxt = '0;
        if (db_up && db_dn) begin
          state_nxt = LOCK;
        end else if (db_up) begin
          enable_nxt    = 1'b1;
          direction_nxt = 1'b1;
          rpt_cnt_nxt   = CNT_W'(1);
          state_nxt     = HOLD;
        end else if (db_dn) begin
          enable_nxt    = 1'b1;
          direction_nxt = 1'b0;
          rpt_cnt_nxt   = CNT_W'(1);
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        // Release is checked first so it beats a repeat due this cycle
        if (!active_c) begin
          state_nxt = IDLE;
        end else if (other_c) begin
          state_nxt = LOCK;
        end else if (REPEAT_DELAY != 0 && rpt_cnt >= DLY_LIM && !enable) begin
          enable_nxt  = 1'b1;
          rpt_cnt_nxt = CNT_W'(1);
          state_nxt   = REPEAT;
        end
      end
      REPEAT: begin
        if (!active_c) begin
          state_nxt = IDLE;
        end else if (other_c) begin
          state_nxt = LOCK;
        end else if (rpt_cnt >= PER_LIM && !enable) begin
          enable_nxt  = 1'b1;
          rpt_cnt_nxt = CNT_W'(1);
        end
      end
      LOCK: begin
        rpt_cnt_nxt = '0;
        if (!db_up && !db_dn) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    lockout_nxt = (state_nxt == LOCK);
  end

endmodule

// File: tb/tb_button_step_ctrl.sv
// Directed self-checking bench for button_step_ctrl (default parameters:
// D=4, repeat delay 16, repeat period 8). Loop index i = rising edge number
// counted from the cycle the stimulus for that step is applied; outputs are
// sampled 1 time unit after each edge.
module tb_button_step_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_up;
  logic btn_down;
  logic enable;
  logic direction;
  logic lockout;

  int vectors = 0;
  int errors  = 0;

  button_step_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .enable    (enable),
    .direction (direction),
    .lockout   (lockout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    #1;
    check("rst_enable", enable, 1'b0);
    check("rst_direction", direction, 1'b1);
    check("rst_lockout", lockout, 1'b0);
    repeat (3) tick();
    rst = 1'b0;

    // 1. idle after reset
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_enable", enable, 1'b0);
      check("idle_direction", direction, 1'b1);
      check("idle_lockout", lockout, 1'b0);
    end

    // 2. single up press, released before the first repeat is due
    for (int i = 0; i < 40; i++) begin
      btn_up = (i < 10);
      tick();
      check("up_press_enable", enable, (i == 6));
      check("up_press_direction", direction, 1'b1);
    end

    // 3. bouncing down button never passes the debouncer
    for (int i = 0; i < 30; i++) begin
      btn_down = (i < 20) && (((i / 2) % 2) == 0);
      tick();
      check("bounce_enable", enable, 1'b0);
      check("bounce_direction", direction, 1'b1);
    end

    // 4. down held 60 cycles: pulses at 6, 22, 30, 38, 46, 54, 62
    for (int i = 0; i < 90; i++) begin
      btn_down = (i < 60);
      tick();
      check("repeat_enable", enable,
            (i == 6) || (i >= 22 && i <= 62 && ((i - 22) % 8) == 0));
      check("repeat_direction", direction, (i >= 6) ? 1'b0 : 1'b1);
      check("repeat_lockout", lockout, 1'b0);
    end

    // 5. up held, down joins at 20: lock at 26, kept until both released
    for (int i = 0; i < 71; i++) begin
      btn_up   = (i < 56);
      btn_down = (i >= 20) && (i < 41);
      tick();
      check("lock_enable", enable, (i == 6) || (i == 22));
      check("lock_lockout", lockout, (i >= 26) && (i < 62));
      check("lock_direction", direction, (i >= 6) ? 1'b1 : 1'b0);
    end

    // 6. reset while repeating, then fresh press after release of rst
    for (int i = 0; i < 23; i++) begin
      btn_down = 1'b1;
      tick();
      check("pre_rst_enable", enable, (i == 6) || (i == 22));
      check("pre_rst_direction", direction, (i >= 6) ? 1'b0 : 1'b1);
    end
    rst = 1'b1;
    #1;
    check("async_rst_enable", enable, 1'b0);
    check("async_rst_direction", direction, 1'b1);
    check("async_rst_lockout", lockout, 1'b0);
    repeat (2) begin
      tick();
      check("in_rst_enable", enable, 1'b0);
    end
    rst = 1'b0;
    // release lands exactly when the first repeat would be due (edge 22)
    for (int i = 0; i < 41; i++) begin
      btn_down = (i < 16);
      tick();
      check("post_rst_enable", enable, (i == 6));
      check("post_rst_direction", direction, (i >= 6) ? 1'b0 : 1'b1);
      check("post_rst_lockout", lockout, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
